// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions for the register-bus responders (read and write).
// Response codes and the read-channel FSM state encoding live here.
package axi4lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

endpackage : axi4lite_pkg

// File: rtl/axi4lite_read.sv
// AXI4-Lite read responder: one AR at a time, single-cycle rd_req to the register
// logic, then an R beat held until accepted; a cycle timeout forces SLVERR.
module axi4lite_read
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  aresetb,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [2:0]            axi_arprot,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  input  logic                  rd_error
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  rd_state_t             r_state;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd_req;
  logic [CNT_W-1:0]      r_cnt;

  rd_state_t             w_state_nxt;
  logic                  w_arready_nxt;
  logic                  w_rvalid_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic [1:0]            w_rresp_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_rd_req_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_timeout;
  logic                  w_unused;

  assign w_unused  = ^{axi_arprot, 1'b0};
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LIMIT);

  // State and all bus-facing outputs are registered; reset abandons any transaction.
  always_ff @(posedge clk or negedge aresetb) begin
    if (!aresetb) begin
      r_state   <= RD_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= AXI_RESP_OKAY;
      r_addr    <= '0;
      r_rd_req  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_addr    <= w_addr_nxt;
      r_rd_req  <= w_rd_req_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // RESP spends its first cycle with rvalid low: the answer is captured on the
  // edge that samples rd_valid (or the timeout), and rvalid follows one edge later.
  always_comb begin
    w_state_nxt   = r_state;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    w_addr_nxt    = r_addr;
    w_rd_req_nxt  = 1'b0;
    w_cnt_nxt     = r_cnt;

    case (r_state)
      RD_IDLE: begin
        if (!r_arready) begin
          w_arready_nxt = 1'b1;
        end else if (axi_arvalid) begin
          w_state_nxt   = RD_REQ;
          w_arready_nxt = 1'b0;
          w_addr_nxt    = axi_araddr;
          w_rd_req_nxt  = 1'b1;
          w_cnt_nxt     = '0;
        end
      end

      RD_REQ: begin
        if (rd_valid) begin
          w_state_nxt = RD_RESP;
          w_rdata_nxt = rd_data;
          w_rresp_nxt = rd_error ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else if (w_timeout) begin
          w_state_nxt = RD_RESP;
          w_rdata_nxt = '0;
          w_rresp_nxt = AXI_RESP_SLVERR;
        end else if (r_cnt != TO_LIMIT) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      RD_RESP: begin
        if (!r_rvalid) begin
          w_rvalid_nxt = 1'b1;
        end else if (axi_rready) begin
          w_state_nxt   = RD_IDLE;
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt   = RD_IDLE;
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = 1'b0;
      end
    endcase
  end

  assign axi_arready = r_arready;
  assign axi_rvalid  = r_rvalid;
  assign axi_rdata   = r_rdata;
  assign axi_rresp   = r_rresp;
  assign addr        = r_addr;
  assign rd_req      = r_rd_req;

endmodule : axi4lite_read

// File: tb/tb_axi4lite_read.sv
// Directed bench for axi4lite_read with TIMEOUT=8: immediate answer, backpressure,
// error response, timeout with a late answer, and reset in the middle of a read.
module tb_axi4lite_read;

  logic        clk;
  logic        aresetb;
  logic [39:0] axiAraddr;
  logic [2:0]  axiArprot;
  logic        axiArvalid;
  logic        axiArready;
  logic [31:0] axiRdata;
  logic [1:0]  axiRresp;
  logic        axiRvalid;
  logic        axiRready;
  logic [39:0] regAddr;
  logic        rdReq;
  logic [31:0] rdData;
  logic        rdValid;
  logic        rdError;

  int checks   = 0;
  int failures = 0;

  axi4lite_read #(
    .ADDR_WIDTH(40),
    .DATA_WIDTH(32),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .aresetb    (aresetb),
    .axi_araddr (axiAraddr),
    .axi_arprot (axiArprot),
    .axi_arvalid(axiArvalid),
    .axi_arready(axiArready),
    .axi_rdata  (axiRdata),
    .axi_rresp  (axiRresp),
    .axi_rvalid (axiRvalid),
    .axi_rready (axiRready),
    .addr       (regAddr),
    .rd_req     (rdReq),
    .rd_data    (rdData),
    .rd_valid   (rdValid),
    .rd_error   (rdError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic arvalid, input logic [39:0] araddr, input logic rvalidIn,
                               input logic [31:0] data, input logic err, input logic rready);
    axiArvalid = arvalid;
    axiAraddr  = araddr;
    rdValid    = rvalidIn;
    rdData     = data;
    rdError    = err;
    axiRready  = rready;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aresetb   = 1'b1;
    axiArprot = 3'b000;
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 aresetb = 1'b0;
    stepClock();
    stepClock();

    $display("[TB] reset state");
    checkOutput("rst_arready", axiArready, 1'b0);
    checkOutput("rst_rvalid",  axiRvalid,  1'b0);
    checkOutput("rst_rd_req",  rdReq,      1'b0);
    checkOutput("rst_rdata",   axiRdata,   32'h0);
    checkOutput("rst_rresp",   axiRresp,   2'b00);
    checkOutput("rst_addr",    regAddr,    40'h0);

    aresetb = 1'b1;
    stepClock();
    checkOutput("rel_arready", axiArready, 1'b1);

    $display("[TB] immediate answer");
    applyStimulus(1'b1, 40'h20, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("imm_rd_req",  rdReq,      1'b1);
    checkOutput("imm_addr",    regAddr,    40'h20);
    checkOutput("imm_arready", axiArready, 1'b0);
    applyStimulus(1'b0, 40'h0, 1'b1, 32'hCAFE0001, 1'b0, 1'b1);
    stepClock();
    checkOutput("imm_rd_req_1cyc", rdReq,     1'b0);
    checkOutput("imm_rvalid_early", axiRvalid, 1'b0);
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("imm_rvalid",  axiRvalid,  1'b1);
    checkOutput("imm_rdata",   axiRdata,   32'hCAFE0001);
    checkOutput("imm_rresp",   axiRresp,   2'b00);
    checkOutput("imm_arready_busy", axiArready, 1'b0);
    stepClock();
    checkOutput("imm_rvalid_done", axiRvalid,  1'b0);
    checkOutput("imm_arready_back", axiArready, 1'b1);
    checkOutput("imm_rdata_hold",  axiRdata,   32'hCAFE0001);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 40'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    stepClock();
    checkOutput("bp_rd_req", rdReq,   1'b1);
    checkOutput("bp_addr",   regAddr, 40'h100);
    applyStimulus(1'b1, 40'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("bp_wait_rd_req", rdReq,     1'b0);
      checkOutput("bp_wait_rvalid", axiRvalid, 1'b0);
    end
    applyStimulus(1'b1, 40'h200, 1'b1, 32'h12345678, 1'b0, 1'b0);
    stepClock();
    checkOutput("bp_rvalid_capture", axiRvalid, 1'b0);
    applyStimulus(1'b1, 40'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    stepClock();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_rvalid",  axiRvalid,  1'b1);
      checkOutput("bp_hold_rdata",   axiRdata,   32'h12345678);
      checkOutput("bp_hold_rresp",   axiRresp,   2'b00);
      checkOutput("bp_hold_arready", axiArready, 1'b0);
      checkOutput("bp_hold_addr",    regAddr,    40'h100);
      stepClock();
    end
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("bp_rvalid_done",  axiRvalid,  1'b0);
    checkOutput("bp_arready_back", axiArready, 1'b1);
    checkOutput("bp_no_2nd_addr",  regAddr,    40'h100);
    checkOutput("bp_no_2nd_req",   rdReq,      1'b0);

    $display("[TB] error response");
    applyStimulus(1'b1, 40'h30, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 40'h0, 1'b1, 32'h0000FFFF, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("err_rvalid", axiRvalid, 1'b1);
    checkOutput("err_rresp",  axiRresp,  2'b10);
    checkOutput("err_rdata",  axiRdata,  32'h0000FFFF);
    stepClock();
    checkOutput("err_rvalid_done", axiRvalid, 1'b0);

    $display("[TB] timeout");
    applyStimulus(1'b1, 40'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      stepClock();
      checkOutput("to_wait_rvalid", axiRvalid, 1'b0);
    end
    stepClock();
    checkOutput("to_rvalid", axiRvalid, 1'b1);
    checkOutput("to_rdata",  axiRdata,  32'h0);
    checkOutput("to_rresp",  axiRresp,  2'b10);
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("to_rvalid_done", axiRvalid,  1'b0);
    checkOutput("to_arready",     axiArready, 1'b1);
    applyStimulus(1'b0, 40'h0, 1'b1, 32'h0000DEAD, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    stepClock();
    checkOutput("late_rvalid",  axiRvalid,  1'b0);
    checkOutput("late_rdata",   axiRdata,   32'h0);
    checkOutput("late_rresp",   axiRresp,   2'b10);
    checkOutput("late_arready", axiArready, 1'b1);

    $display("[TB] reset mid-transaction");
    applyStimulus(1'b1, 40'h50, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    #2 aresetb = 1'b0;
    #1;
    checkOutput("mid_rst_arready", axiArready, 1'b0);
    checkOutput("mid_rst_rvalid",  axiRvalid,  1'b0);
    checkOutput("mid_rst_rd_req",  rdReq,      1'b0);
    checkOutput("mid_rst_rdata",   axiRdata,   32'h0);
    checkOutput("mid_rst_rresp",   axiRresp,   2'b00);
    checkOutput("mid_rst_addr",    regAddr,    40'h0);
    stepClock();
    aresetb = 1'b1;
    stepClock();
    checkOutput("mid_rel_arready", axiArready, 1'b1);
    checkOutput("mid_rel_rvalid",  axiRvalid,  1'b0);
    stepClock();
    checkOutput("mid_no_stray", axiRvalid, 1'b0);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 40'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("b2b0_rd_req", rdReq,   1'b1);
    checkOutput("b2b0_addr",   regAddr, 40'h0);
    applyStimulus(1'b1, 40'h4, 1'b1, 32'h000000A0, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b1, 40'h4, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("b2b0_rvalid", axiRvalid, 1'b1);
    checkOutput("b2b0_rdata",  axiRdata,  32'h000000A0);
    checkOutput("b2b0_addr_hold", regAddr, 40'h0);
    stepClock();
    checkOutput("b2b0_done",    axiRvalid,  1'b0);
    checkOutput("b2b0_arready", axiArready, 1'b1);
    stepClock();
    checkOutput("b2b1_rd_req", rdReq,   1'b1);
    checkOutput("b2b1_addr",   regAddr, 40'h4);
    applyStimulus(1'b0, 40'h0, 1'b1, 32'h000000B4, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 40'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    stepClock();
    checkOutput("b2b1_rvalid", axiRvalid, 1'b1);
    checkOutput("b2b1_rdata",  axiRdata,  32'h000000B4);
    checkOutput("b2b1_rresp",  axiRresp,  2'b00);
    stepClock();
    checkOutput("b2b1_done", axiRvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axi4lite_read
